// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: oldest-first issue of ready station entries to ALU_NUM functional units
// Ports: clk/rst_n (async active-low), flush squashes selection and busy state;
//   rob_head plus ent_* describe the station; clear_entry frees granted entries this cycle;
//   issue_valid/issue_idx/issue_robn are the registered grants; fu_busy marks FUs in a multi-cycle op.
module fu_issue_scheduler #(
   parameter int STATION_ROWS = 8,
   parameter int ROB_ROWS = 16,
   parameter int ALU_NUM = 3,
   parameter int ALUOP_BITS = 3,
   parameter logic [ALUOP_BITS-1:0] MUL_OP = 3'b010,
   parameter int MUL_LAT = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic [$clog2(ROB_ROWS)-1:0] rob_head,
   input  logic [STATION_ROWS-1:0] ent_ready,
   input  logic [STATION_ROWS-1:0][$clog2(ROB_ROWS)-1:0] ent_robn,
   input  logic [STATION_ROWS-1:0][ALUOP_BITS-1:0] ent_aluop,
   input  logic [STATION_ROWS-1:0] ent_is_mem,
   output logic [STATION_ROWS-1:0] clear_entry,
   output logic [ALU_NUM-1:0] issue_valid,
   output logic [ALU_NUM-1:0][$clog2(STATION_ROWS)-1:0] issue_idx,
   output logic [ALU_NUM-1:0][$clog2(ROB_ROWS)-1:0] issue_robn,
   output logic [ALU_NUM-1:0] fu_busy
);
   localparam int RW = $clog2(ROB_ROWS);
   localparam int SW = $clog2(STATION_ROWS);
   logic [ALU_NUM-1:0][3:0] cnt;
   logic [ALU_NUM-1:0] gv, gmul, taken;
   logic [ALU_NUM-1:0][SW-1:0] gidx;
   logic [ALU_NUM-1:0][RW-1:0] grobn;
   logic placed;
   logic [RW-1:0] age;
   always_comb
      for (int i = 0; i < ALU_NUM; i++) fu_busy[i] = cnt[i] != 4'd0;
   // Sweeping ages outermost and indices innermost visits candidates oldest-first with
   // index tie-break; each takes the lowest free FU it is eligible for, skipping when none fits.
   always_comb begin
      gv = '0;
      gmul = '0;
      gidx = '0;
      grobn = '0;
      clear_entry = '0;
      taken = fu_busy;
      placed = 1'b0;
      age = '0;
      for (int a = 0; a < ROB_ROWS; a++)
         for (int j = 0; j < STATION_ROWS; j++) begin
            age = ent_robn[j] - rob_head;
            placed = !(rst_n && !flush && ent_ready[j] && age == RW'(a));
            for (int i = 0; i < ALU_NUM; i++)
               if (!placed && !taken[i] && (i == 0 || !ent_is_mem[j])) begin
                  placed = 1'b1;
                  taken[i] = 1'b1;
                  gv[i] = 1'b1;
                  gidx[i] = SW'(j);
                  grobn[i] = ent_robn[j];
                  gmul[i] = ent_aluop[j] == MUL_OP;
                  clear_entry[j] = 1'b1;
               end
         end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         issue_valid <= '0;
         issue_idx <= '0;
         issue_robn <= '0;
         cnt <= '0;
      end else begin
         issue_valid <= gv;
         for (int i = 0; i < ALU_NUM; i++) begin
            if (gv[i]) begin
               issue_idx[i] <= gidx[i];
               issue_robn[i] <= grobn[i];
            end
            cnt[i] <= flush ? 4'd0 : gv[i] ? (gmul[i] ? 4'(MUL_LAT - 1) : 4'd0) :
                      (cnt[i] != 4'd0 ? cnt[i] - 4'd1 : 4'd0);
         end
      end
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: directed and randomized checks of fu_issue_scheduler against a sorting reference model
module tb_fu_issue_scheduler;
   localparam int MUL_LAT = 3;
   logic clk, rst_n, flush;
   logic [3:0] rob_head;
   logic [7:0] ent_ready, ent_is_mem, clear_entry;
   logic [7:0][3:0] ent_robn;
   logic [7:0][2:0] ent_aluop;
   logic [2:0] issue_valid, fu_busy;
   logic [2:0][2:0] issue_idx;
   logic [2:0][3:0] issue_robn;
   int n_chk = 0, n_err = 0;
   int cyc;
   int free_at[3];
   int e_idx[3], e_robn[3];
   logic [7:0] m_clear;
   logic [2:0] m_gv, m_gmul;
   int m_gidx[3], m_grobn[3];

   fu_issue_scheduler dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head),
      .ent_ready(ent_ready), .ent_robn(ent_robn), .ent_aluop(ent_aluop),
      .ent_is_mem(ent_is_mem), .clear_entry(clear_entry), .issue_valid(issue_valid),
      .issue_idx(issue_idx), .issue_robn(issue_robn), .fu_busy(fu_busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int key(int j);
      return ((int'(ent_robn[j]) - int'(rob_head) + 16) % 16) * 8 + j;
   endfunction

   function automatic bit m_busy(int i);
      return cyc < free_at[i];
   endfunction

   task automatic mreset();
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
         free_at[i] = 0;
         e_idx[i] = 0;
         e_robn[i] = 0;
      end
   endtask

   task automatic model_sel();
      int ord[8];
      int n, t;
      bit used[3];
      n = 0;
      m_clear = '0;
      m_gv = '0;
      m_gmul = '0;
      for (int i = 0; i < 3; i++) begin
         used[i] = m_busy(i);
         m_gidx[i] = 0;
         m_grobn[i] = 0;
      end
      if (!flush)
         for (int j = 0; j < 8; j++)
            if (ent_ready[j]) begin
               ord[n] = j;
               n++;
            end
      for (int a = 1; a < n; a++)
         for (int b = a; b > 0 && key(ord[b]) < key(ord[b-1]); b--) begin
            t = ord[b];
            ord[b] = ord[b-1];
            ord[b-1] = t;
         end
      for (int k = 0; k < n; k++)
         for (int i = 0; i < 3; i++)
            if (!used[i] && (i == 0 || !ent_is_mem[ord[k]])) begin
               used[i] = 1;
               m_gv[i] = 1;
               m_gidx[i] = ord[k];
               m_grobn[i] = int'(ent_robn[ord[k]]);
               m_gmul[i] = ent_aluop[ord[k]] == 3'b010;
               m_clear[ord[k]] = 1;
               break;
            end
   endtask

   task automatic cycle();
      #1;
      model_sel();
      chk("clear", 32'(clear_entry), 32'(m_clear));
      for (int i = 0; i < 3; i++) chk($sformatf("busy%0d", i), 32'(fu_busy[i]), 32'(m_busy(i)));
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (flush) free_at[i] = 0;
         else if (m_gv[i] && m_gmul[i]) free_at[i] = cyc + MUL_LAT;
         if (m_gv[i]) begin
            e_idx[i] = m_gidx[i];
            e_robn[i] = m_grobn[i];
         end
      end
      cyc++;
      chk("valid", 32'(issue_valid), 32'(m_gv));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("idx%0d", i), 32'(issue_idx[i]), 32'(e_idx[i]));
         chk($sformatf("robn%0d", i), 32'(issue_robn[i]), 32'(e_robn[i]));
      end
      @(negedge clk);
   endtask

   task automatic idle();
      ent_ready = '0;
      ent_is_mem = '0;
      ent_aluop = '0;
      for (int j = 0; j < 8; j++) ent_robn[j] = 4'(j + 8);
   endtask

   task automatic set_ent(input int j, input int robn, input logic [2:0] op, input logic mem);
      ent_ready[j] = 1;
      ent_robn[j] = 4'(robn);
      ent_aluop[j] = op;
      ent_is_mem[j] = mem;
   endtask

   initial begin
      int perm[16];
      int t, r;
      rst_n = 0;
      flush = 0;
      rob_head = 0;
      idle();
      for (int j = 0; j < 8; j++) set_ent(j, j, 3'd0, 1'b0);
      mreset();
      repeat (2) @(negedge clk);
      chk("rst_clear", 32'(clear_entry), 32'd0);
      chk("rst_valid", 32'(issue_valid), 32'd0);
      chk("rst_busy", 32'(fu_busy), 32'd0);
      rst_n = 1;
      #1;
      chk("rel_grants", 32'($countones(clear_entry)), 32'd3);
      cycle();

      idle();
      rob_head = 14;
      set_ent(0, 1, 3'd0, 0);
      set_ent(1, 15, 3'd0, 0);
      set_ent(2, 0, 3'd0, 0);
      set_ent(3, 3, 3'd0, 0);
      #1;
      chk("wrap_clear", 32'(clear_entry), 32'h07);
      cycle();
      chk("wrap_robn", 32'(issue_robn), 32'h10f);

      idle();
      rob_head = 0;
      set_ent(0, 2, 3'd0, 1);
      set_ent(1, 3, 3'd0, 1);
      set_ent(2, 4, 3'd0, 0);
      #1;
      chk("mem_clear", 32'(clear_entry), 32'h05);
      cycle();
      chk("mem_valid", 32'(issue_valid), 32'h3);

      idle();
      set_ent(0, 0, 3'b010, 0);
      cycle();
      idle();
      set_ent(1, 1, 3'd1, 1);
      set_ent(2, 2, 3'd1, 0);
      set_ent(3, 3, 3'd1, 0);
      #1;
      chk("mul_busy1", 32'(fu_busy), 32'h1);
      chk("mul_memwait1", 32'(clear_entry), 32'h0c);
      cycle();
      ent_ready[3:2] = 2'b00;
      set_ent(4, 4, 3'd0, 0);
      set_ent(5, 5, 3'd0, 0);
      #1;
      chk("mul_busy2", 32'(fu_busy), 32'h1);
      chk("mul_memwait2", 32'(clear_entry), 32'h30);
      cycle();
      ent_ready[5:4] = 2'b00;
      #1;
      chk("mul_free3", 32'(fu_busy), 32'h0);
      chk("mul_memgo", 32'(clear_entry), 32'h02);
      cycle();

      idle();
      rob_head = 6;
      set_ent(0, 6, 3'b010, 0);
      cycle();
      idle();
      set_ent(1, 7, 3'd0, 0);
      flush = 1;
      #1;
      chk("flush_clear", 32'(clear_entry), 32'h0);
      cycle();
      flush = 0;
      chk("flush_valid", 32'(issue_valid), 32'h0);
      chk("flush_busy", 32'(fu_busy), 32'h0);
      #1;
      chk("flush_resume", 32'(clear_entry), 32'h02);
      cycle();

      idle();
      rob_head = 0;
      set_ent(0, 0, 3'b010, 0);
      set_ent(1, 1, 3'd0, 0);
      set_ent(2, 2, 3'd0, 0);
      cycle();
      idle();
      chk("pre_arst_valid", 32'(issue_valid), 32'h7);
      #2;
      rst_n = 0;
      #1;
      chk("arst_valid", 32'(issue_valid), 32'h0);
      chk("arst_busy", 32'(fu_busy), 32'h0);
      chk("arst_robn", 32'(issue_robn), 32'h0);
      mreset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;

      repeat (400) begin
         for (int i = 0; i < 16; i++) perm[i] = i;
         for (int i = 15; i > 0; i--) begin
            r = $urandom_range(0, i);
            t = perm[i];
            perm[i] = perm[r];
            perm[r] = t;
         end
         rob_head = 4'($urandom);
         ent_ready = 8'($urandom);
         for (int j = 0; j < 8; j++) begin
            ent_robn[j] = 4'(perm[j]);
            ent_is_mem[j] = $urandom_range(0, 3) == 0;
            ent_aluop[j] = $urandom_range(0, 3) == 0 ? 3'b010 : 3'($urandom);
         end
         flush = $urandom_range(0, 15) == 0;
         cycle();
      end
      flush = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
